// File: rtl/branch_evaluator.sv
// branch_evaluator
//   Multi-cycle branch comparator. It latches two operands and a RISC-V branch
//   funct3, then compares them DIGIT bits per cycle starting at the most
//   significant digit. It produces equal / signed-less / unsigned-less flags
//   and the resulting branch decision.
//
// Parameters
//   WIDTH       operand width in bits
//   DIGIT       bits compared per cycle (must divide WIDTH)
//   EARLY_EXIT  1: finish on the first differing digit, 0: always scan all digits
//
// Ports
//   i_clock           rising-edge clock
//   i_reset           asynchronous active-low reset
//   i_flush           synchronous abort of any in-flight comparison
//   i_valid/o_ready   request handshake
//   i_dataA/i_dataB   operands (rs1 / rs2)
//   i_op              branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU, 010/011 illegal)
//   o_valid/i_ready   result handshake
//   o_isEqual, o_isLessSigned, o_isLessUnsigned   comparison flags
//   o_taken           branch condition for the latched op
//   o_illegal         latched op was 010 or 011
module branch_evaluator #(
  parameter int WIDTH      = 32,
  parameter int DIGIT      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_isEqual,
  output logic             o_isLessSigned,
  output logic             o_isLessUnsigned,
  output logic             o_taken,
  output logic             o_illegal
);

  localparam int N    = WIDTH / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [DIGIT-1:0] SIGN_FLIP = DIGIT'(1) << (DIGIT - 1);

  generate
    if ((WIDTH % DIGIT) != 0) begin : gBadDigit
      $error("branch_evaluator: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} stateT;

  stateT            state, nextState;
  logic [WIDTH-1:0] aReg, bReg;
  logic [2:0]       opReg;
  logic [IDXW-1:0]  idx;
  logic             isEqualReg, lessSReg, lessUReg, diffFound;

  logic             accept;
  logic [DIGIT-1:0] digA, digB;
  logic             digDiff, digLessU, digLessS, atTop, atBottom;

  // The operands are shifted left once per scanned digit, so the digit being
  // examined always sits in the top DIGIT bits of the operand registers.
  assign digA     = aReg[WIDTH-1 -: DIGIT];
  assign digB     = bReg[WIDTH-1 -: DIGIT];
  assign digDiff  = (digA != digB);
  assign digLessU = (digA < digB);
  // Inverting the sign bit turns a two's-complement compare into an unsigned one.
  assign digLessS = ((digA ^ SIGN_FLIP) < (digB ^ SIGN_FLIP));
  assign atTop    = (idx == IDXW'(N - 1));
  assign atBottom = (idx == '0);

  assign accept = (state == IDLE) && i_valid && !i_flush;

  // Next-state logic. A flush always wins, including over the result handshake.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = SCAN;
      SCAN: if (atBottom || (digDiff && (EARLY_EXIT != 0))) nextState = DONE;
      DONE: if (i_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (i_flush) nextState = IDLE;
  end

  // State and datapath registers. Only the first differing digit sets the
  // flags, which keeps the result correct when the full scan is forced.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      aReg       <= '0;
      bReg       <= '0;
      opReg      <= '0;
      idx        <= '0;
      isEqualReg <= 1'b0;
      lessSReg   <= 1'b0;
      lessUReg   <= 1'b0;
      diffFound  <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        aReg       <= i_dataA;
        bReg       <= i_dataB;
        opReg      <= i_op;
        idx        <= IDXW'(N - 1);
        isEqualReg <= 1'b1;
        lessSReg   <= 1'b0;
        lessUReg   <= 1'b0;
        diffFound  <= 1'b0;
      end else if ((state == SCAN) && !i_flush) begin
        aReg <= aReg << DIGIT;
        bReg <= bReg << DIGIT;
        idx  <= idx - IDXW'(1);
        if (digDiff && !diffFound) begin
          diffFound  <= 1'b1;
          isEqualReg <= 1'b0;
          lessUReg   <= digLessU;
          lessSReg   <= atTop ? digLessS : digLessU;
        end
      end
    end
  end

  // Result outputs are only exposed in DONE so idle/reset values are all zero.
  always_comb begin
    o_ready          = (state == IDLE);
    o_valid          = (state == DONE);
    o_isEqual        = o_valid && isEqualReg;
    o_isLessSigned   = o_valid && lessSReg;
    o_isLessUnsigned = o_valid && lessUReg;
    o_illegal        = o_valid && (opReg[2:1] == 2'b01);
    o_taken          = 1'b0;
    case (opReg)
      3'b000:  o_taken = isEqualReg;
      3'b001:  o_taken = !isEqualReg;
      3'b100:  o_taken = lessSReg;
      3'b101:  o_taken = !lessSReg;
      3'b110:  o_taken = lessUReg;
      3'b111:  o_taken = !lessUReg;
      default: o_taken = 1'b0;
    endcase
    o_taken = o_taken && o_valid;
  end

endmodule

// File: tb/tb_branch_evaluator.sv
// tb_branch_evaluator
//   Directed and randomized checks of branch_evaluator (WIDTH=32, DIGIT=8,
//   EARLY_EXIT=1) against a whole-word reference model.
module tb_branch_evaluator;

  logic        clock = 1'b0;
  logic        resetN, flush, inValid, inReady;
  logic        outReady, outValid;
  logic [31:0] dataA, dataB;
  logic [2:0]  op;
  logic        isEqual, isLessS, isLessU, taken, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  branch_evaluator #(.WIDTH(32), .DIGIT(8), .EARLY_EXIT(1)) dut (
    .i_clock(clock), .i_reset(resetN), .i_flush(flush), .i_valid(inValid),
    .o_ready(outReady), .i_dataA(dataA), .i_dataB(dataB), .i_op(op),
    .o_valid(outValid), .i_ready(inReady), .o_isEqual(isEqual),
    .o_isLessSigned(isLessS), .o_isLessUnsigned(isLessU),
    .o_taken(taken), .o_illegal(illegal)
  );

  // Reference model: whole-word comparisons and the first differing byte.
  function automatic int modelLatency(input logic [31:0] a, input logic [31:0] b);
    for (int k = 1; k <= 4; k++)
      if ((a >> (32 - 8 * k)) != (b >> (32 - 8 * k))) return k;
    return 4;
  endfunction

  function automatic logic modelTaken(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    checkOutput({tag, " valid"}, 32'(outValid), 32'd1);
    checkOutput({tag, " ready"}, 32'(outReady), 32'd0);
    checkOutput({tag, " flags"}, {27'd0, isEqual, isLessS, isLessU, taken, illegal},
                {27'd0, a == b, $signed(a) < $signed(b), a < b, modelTaken(o, a, b), o[2:1] == 2'b01});
  endtask

  // One full transaction: accept, measure latency, hold in DONE, hand off.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int hold);
    int cycles;
    @(negedge clock);
    checkOutput({tag, " ready before accept"}, 32'(outReady), 32'd1);
    op = o; dataA = a; dataB = b; inValid = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    cycles = 0;
    while (!outValid && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, 32'(cycles), 32'(modelLatency(a, b)));
    checkResult(tag, o, a, b);
    for (int h = 0; h < hold; h++) begin
      inValid = 1'b1;
      dataA = $urandom; dataB = $urandom; op = 3'($urandom);
      @(posedge clock); #1;
      checkResult({tag, " hold"}, o, a, b);
    end
    inReady = 1'b1;
    @(posedge clock); #1;
    inReady = 1'b0;
    inValid = 1'b0;
    checkOutput({tag, " back to idle"}, {30'd0, outReady, outValid}, 32'd2);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  o;
    int          pos;

    resetN = 1'b0; flush = 1'b0; inValid = 1'b0; inReady = 1'b0;
    dataA = '0; dataB = '0; op = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset outputs", {25'd0, outReady, outValid, isEqual, isLessS, isLessU, taken, illegal},
                32'h40);
    resetN = 1'b1;

    applyStimulus("beq equal", 3'b000, 32'h12345678, 32'h12345678, 0);
    applyStimulus("blt neg", 3'b100, 32'hFFFFFFFF, 32'h00000001, 0);
    applyStimulus("bltu neg", 3'b110, 32'hFFFFFFFF, 32'h00000001, 0);
    applyStimulus("bgeu byte1", 3'b111, 32'h00000100, 32'h000000FF, 0);
    applyStimulus("bne hold", 3'b001, 32'hDEAD0000, 32'hDEAD0001, 5);
    applyStimulus("illegal 010", 3'b010, 32'd5, 32'd5, 0);
    applyStimulus("illegal 011", 3'b011, 32'h80000000, 32'd5, 0);
    applyStimulus("bge signed", 3'b101, 32'h7FFFFFFF, 32'h80000000, 0);

    // Flush in the second SCAN cycle must discard the result.
    @(negedge clock);
    op = 3'b000; dataA = 32'h12345678; dataB = 32'h12345678; inValid = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checkOutput("flush to idle", {30'd0, outReady, outValid}, 32'd2);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      checkOutput("flush no valid", {30'd0, outReady, outValid}, 32'd2);
    end

    // Asynchronous reset in the middle of SCAN.
    @(negedge clock);
    op = 3'b000; dataA = 32'hAAAAAAAA; dataB = 32'hAAAAAAAA; inValid = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock); #2;
    resetN = 1'b0;
    #1;
    checkOutput("async reset", {25'd0, outReady, outValid, isEqual, isLessS, isLessU, taken, illegal},
                32'h40);
    @(negedge clock);
    resetN = 1'b1;
    applyStimulus("after reset", 3'b110, 32'h01020304, 32'h01020305, 0);

    // Random operands; b often shares the upper bytes of a to vary latency.
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      o = 3'($urandom);
      pos = $urandom_range(0, 4);
      if (pos == 4) b = a;
      else if (n % 3 == 0) b = $urandom;
      else b = a ^ (32'($urandom_range(1, 255)) << (8 * pos));
      applyStimulus("random", o, a, b, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_evaluator.md
BRANCH_EVALUATOR -- requirements
Module: branch_evaluator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 8, meaning the bits compared per cycle; WIDTH mod DIGIT SHALL be 0 (elaboration error otherwise); N = WIDTH/DIGIT.
REQ-003 The block SHALL have parameter EARLY_EXIT, default 1, meaning finish on the first differing digit (1) or always scan N digits (0).
REQ-004 i_clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_flush  input  1  synchronous abort of any in-flight comparison.
REQ-007 i_valid  input  1  request valid.
REQ-008 o_ready  output  1  block can accept a request.
REQ-009 i_dataA / i_dataB  input  WIDTH each  operands (rs1 / rs2).
REQ-010 i_op  input  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 illegal.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  consumer accepts result.
REQ-013 o_isEqual, o_isLessSigned, o_isLessUnsigned  output  1 each  comparison flags.
REQ-014 o_taken  output  1  branch condition true for the latched op.
REQ-015 o_illegal  output  1  latched op was 010 or 011.

Function
REQ-016 The FSM SHALL have states IDLE, SCAN and DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-017 Accept SHALL occur when i_valid && o_ready && !i_flush: latch A, B and op, set digit index to N-1 (most significant digit), go to SCAN.
REQ-018 In SCAN, each cycle SHALL compare digit[index] of A and B.
REQ-019 On a differing digit with EARLY_EXIT=1, the block SHALL record lessU = (digitA < digitB) unsigned and go to DONE.
REQ-020 At index N-1, lessS SHALL use a signed digit compare (MSB inverted); below N-1, lessS = lessU.
REQ-021 Equal digits at index 0 SHALL go to DONE with isEqual=1 and lessS=lessU=0; otherwise the index decrements.
REQ-022 With EARLY_EXIT=0, only the first difference SHALL be recorded and DONE SHALL be entered after index 0.
REQ-023 Latency: the k-th digit from the top differing (k=1..N) SHALL give o_valid exactly k cycles after the accept edge; equal operands SHALL give N cycles; EARLY_EXIT=0 SHALL always give N cycles.
REQ-024 o_taken: BEQ=isEqual, BNE=!isEqual, BLT=lessS, BGE=!lessS, BLTU=lessU, BGEU=!lessU; illegal op SHALL give o_taken=0 and o_illegal=1 with flags still computed.
REQ-025 In DONE, all outputs SHALL hold stable until i_ready=1; on that edge the FSM SHALL return to IDLE (no same-cycle re-accept).
REQ-026 i_valid during SCAN/DONE SHALL be ignored (o_ready=0).
REQ-027 i_flush=1 in any state SHALL force IDLE next edge, discard the result (no o_valid) and take priority over accept and over the DONE handshake.
REQ-028 DIGIT==WIDTH SHALL be legal and give a 1-cycle latency.

Reset
REQ-029 While i_reset=0, state SHALL be IDLE, o_valid=0, o_ready=1, and all flags, o_taken and o_illegal SHALL be 0.
REQ-030 Reset assertion mid-SCAN or in DONE SHALL abort immediately (asynchronously); after release the block SHALL accept a new request on the first edge.

Verification (WIDTH=32, DIGIT=8, EARLY_EXIT=1)
REQ-031 BEQ, A=B=0x12345678 -> o_valid 4 cycles after accept, isEqual=1, lessS=lessU=0, taken=1.
REQ-032 BLT, A=0xFFFFFFFF, B=0x00000001 -> o_valid after 1 cycle, lessS=1, lessU=0, taken=1; same operands with BLTU -> taken=0.
REQ-033 BGEU, A=0x00000100, B=0x000000FF -> o_valid after 3 cycles, lessU=0, taken=1.
REQ-034 i_ready=0 for 5 cycles in DONE with i_valid=1 -> outputs stable, o_ready=0, no new accept; i_ready=1 -> IDLE next cycle.
REQ-035 i_flush pulse in the 2nd SCAN cycle, then reset asserted mid-SCAN on a second request -> IDLE, o_valid never asserted; the next request completes normally.
REQ-036 i_op=010, A=5, B=5 -> isEqual=1, o_illegal=1, o_taken=0.
